// File: rtl/mcpu_text_console.sv
// rtl/mcpu_text_console.sv - text-mode console engine turning a byte stream into VRAM writes
//
// Terminal-style character sink for the 32x32-cell text pages of mcpu_gpu.
// Cell address = {page[2:0], row[4:0], col[4:0]}.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data/in_valid        byte stream in; accepted when in_valid & in_ready
//   in_ready, busy          engine idle / not idle (busy = ~in_ready)
//   page                    text page, sampled when a byte is accepted
//   bus_req, bus_gnt        VRAM write-port request / grant
//   vram_addr/wdata/we      VRAM write port (address also used for scroll reads)
//   vram_rdata              VRAM read data, combinational from vram_addr
//   cur_row, cur_col        cursor position
module mcpu_text_console #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  page,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [12:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata,
  output logic [4:0]  cur_row,
  output logic [4:0]  cur_col,
  output logic        busy
);

  localparam int ROWS = 32;
  localparam int COLS = 32;
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  // last destination cell of the row copy; cells above it are the blanked bottom row
  localparam logic [9:0] SCR_LAST  = 10'((ROWS - 1) * COLS - 1);
  localparam logic [9:0] CELL_LAST = 10'(ROWS * COLS - 1);

  typedef enum logic [2:0] {
    IDLE, PUT, BS_ERASE, SCR_RD, SCR_WR, SCR_FILL, CLS
  } state_t;

  state_t      r_state, w_state_n;
  logic [4:0]  r_row, w_row_n;
  logic [4:0]  r_col, w_col_n;
  logic [2:0]  r_page, w_page_n;
  logic [7:0]  r_data, w_data_n;   // character to print, or the scroll read latch
  logic [9:0]  r_cnt, w_cnt_n;     // cell index for scroll and clear
  logic        r_rst_done;         // keeps in_ready low until the first edge out of reset

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_page     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_row      <= w_row_n;
      r_col      <= w_col_n;
      r_page     <= w_page_n;
      r_data     <= w_data_n;
      r_cnt      <= w_cnt_n;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_row_n   = r_row;
    w_col_n   = r_col;
    w_page_n  = r_page;
    w_data_n  = r_data;
    w_cnt_n   = r_cnt;
    case (r_state)
      IDLE: begin
        if (in_valid && r_rst_done) begin
          w_page_n = page;
          w_data_n = in_data;
          case (in_data)
            8'h0A: begin
              w_col_n = '0;
              // moving past the last row scrolls instead of leaving the page
              if (r_row == LAST_ROW) begin
                w_cnt_n   = '0;
                w_state_n = SCR_RD;
              end else begin
                w_row_n = r_row + 5'd1;
              end
            end
            8'h0D: w_col_n = '0;
            8'h08: begin
              if (r_col != '0) begin
                w_col_n   = r_col - 5'd1;
                w_state_n = BS_ERASE;
              end
            end
            8'h0C: begin
              w_cnt_n   = '0;
              w_state_n = CLS;
            end
            default: w_state_n = PUT;
          endcase
        end
      end
      PUT: begin
        if (bus_gnt) begin
          if (r_col == LAST_COL) begin
            w_col_n = '0;
            if (r_row == LAST_ROW) begin
              w_cnt_n   = '0;
              w_state_n = SCR_RD;
            end else begin
              w_row_n   = r_row + 5'd1;
              w_state_n = IDLE;
            end
          end else begin
            w_col_n   = r_col + 5'd1;
            w_state_n = IDLE;
          end
        end
      end
      BS_ERASE: if (bus_gnt) w_state_n = IDLE;
      SCR_RD: begin
        if (bus_gnt) begin
          w_data_n  = vram_rdata;
          w_state_n = SCR_WR;
        end
      end
      SCR_WR: begin
        if (bus_gnt) begin
          w_cnt_n   = r_cnt + 10'd1;
          w_state_n = (r_cnt == SCR_LAST) ? SCR_FILL : SCR_RD;
        end
      end
      SCR_FILL: begin
        if (bus_gnt) begin
          w_cnt_n = r_cnt + 10'd1;
          if (r_cnt == CELL_LAST) w_state_n = IDLE;
        end
      end
      CLS: begin
        if (bus_gnt) begin
          w_cnt_n = r_cnt + 10'd1;
          if (r_cnt == CELL_LAST) begin
            w_row_n   = '0;
            w_col_n   = '0;
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    vram_addr  = '0;
    vram_wdata = '0;
    case (r_state)
      PUT: begin
        vram_addr  = {r_page, r_row, r_col};
        vram_wdata = r_data;
      end
      BS_ERASE: begin
        vram_addr  = {r_page, r_row, r_col};
        vram_wdata = FILL_CHAR;
      end
      SCR_RD:  vram_addr = {r_page, 10'(r_cnt + 10'd32)};
      SCR_WR: begin
        vram_addr  = {r_page, r_cnt};
        vram_wdata = r_data;
      end
      SCR_FILL, CLS: begin
        vram_addr  = {r_page, r_cnt};
        vram_wdata = FILL_CHAR;
      end
      default: ;
    endcase
  end

  assign vram_we  = bus_gnt && (r_state != IDLE) && (r_state != SCR_RD);
  assign bus_req  = (r_state != IDLE);
  assign in_ready = r_rst_done && (r_state == IDLE);
  assign busy     = ~in_ready;
  assign cur_row  = r_row;
  assign cur_col  = r_col;

endmodule

// File: tb/tb_mcpu_text_console.sv
// tb/tb_mcpu_text_console.sv - randomized self-checking bench for mcpu_text_console
module tb_mcpu_text_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  page = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b1;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [4:0]  cur_row;
  logic [4:0]  cur_col;
  logic        busy;

  mcpu_text_console dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .page(page), .bus_req(bus_req), .bus_gnt(bus_gnt), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  always #5 clk = ~clk;

  bit [7:0]    dut_mem [0:8191];
  bit [7:0]    ref_mem [0:8191];
  int          n_tests = 0;
  int          n_fail = 0;
  int          wr_count = 0;
  logic [12:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          ref_row = 0;
  int          ref_col = 0;
  logic [2:0]  op_page = '0;
  bit          gnt_random = 1'b0;
  bit          seq_on = 1'b0;
  logic [12:0] seq_addr = '0;
  int          lat;
  int          nw;

  assign vram_rdata = dut_mem[vram_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (vram_we) begin
      dut_mem[vram_addr] <= vram_wdata;
      wr_count  <= wr_count + 1;
      last_addr <= vram_addr;
      last_data <= vram_wdata;
      if (seq_on) begin
        chk("cls_addr_seq", vram_addr, seq_addr);
        seq_addr = seq_addr + 13'd1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus_gnt = gnt_random ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", busy, !in_ready);
      if (!bus_gnt) chk("we_without_gnt", vram_we, 0);
      if (in_ready) chk("req_when_idle", bus_req, 0);
      if (vram_we) chk("write_page", vram_addr[12:10], op_page);
    end
  end

  task automatic scroll_model(input int p);
    int base;
    base = p * 1024;
    for (int i = 0; i < 992; i++) ref_mem[base + i] = ref_mem[base + i + 32];
    for (int i = 992; i < 1024; i++) ref_mem[base + i] = 8'h20;
  endtask

  task automatic model_apply(input logic [7:0] b, input int p, output int exp_w);
    int base;
    base = p * 1024;
    exp_w = 0;
    case (b)
      8'h0A: begin
        ref_col = 0;
        if (ref_row == 31) begin scroll_model(p); exp_w = 1024; end
        else ref_row++;
      end
      8'h0D: ref_col = 0;
      8'h08: if (ref_col > 0) begin
        ref_col--;
        ref_mem[base + ref_row * 32 + ref_col] = 8'h20;
        exp_w = 1;
      end
      8'h0C: begin
        for (int i = 0; i < 1024; i++) ref_mem[base + i] = 8'h20;
        ref_row = 0; ref_col = 0; exp_w = 1024;
      end
      default: begin
        ref_mem[base + ref_row * 32 + ref_col] = b;
        exp_w = 1;
        ref_col++;
        if (ref_col == 32) begin
          ref_col = 0;
          if (ref_row == 31) begin scroll_model(p); exp_w += 1024; end
          else ref_row++;
        end
      end
    endcase
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50000);
    chk("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b, input logic [2:0] p, output int cycles, output int writes);
    int exp_w, w0, n;
    @(posedge clk); #1;
    in_data = b; page = p; in_valid = 1'b1;
    wait_ready(n);
    w0 = wr_count;
    op_page = p;
    @(posedge clk); #1;
    in_valid = 1'b0; page = 3'($urandom); in_data = 8'($urandom);
    model_apply(b, int'(p), exp_w);
    wait_ready(cycles);
    writes = wr_count - w0;
    chk($sformatf("writes_for_%02h", b), writes, exp_w);
    chk("cur_row", cur_row, ref_row);
    chk("cur_col", cur_col, ref_col);
  endtask

  task automatic check_page(input int p);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dut_mem[p * 1024 + i] != ref_mem[p * 1024 + i]) bad++;
    chk($sformatf("page%0d_bad_cells", p), bad, 0);
  endtask

  function automatic logic [7:0] rnd_print();
    return 8'($urandom_range(33, 126));
  endfunction

  initial begin
    logic [7:0] q [3];
    logic [7:0] b;
    int n, w0, exp_w, r;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_vram_addr", vram_addr, 0);
    chk("rst_vram_wdata", vram_wdata, 0);
    chk("rst_cursor", {cur_row, cur_col}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("ready_before_edge", in_ready, 0);
    @(negedge clk); chk("ready_after_edge", in_ready, 1);

    // T1
    send(8'h41, 3'd2, lat, nw);
    chk("t1_addr", last_addr, 13'h800);
    chk("t1_data", last_data, 8'h41);
    chk("t1_latency", lat, 2);
    chk("t1_cursor", {cur_row, cur_col}, {5'd0, 5'd1});

    // T2: wrap, CR, BS at col 0, BS erase
    for (int i = 0; i < 30; i++) send(rnd_print(), 3'd0, lat, nw);
    chk("t2_at_col31", cur_col, 31);
    send(8'h42, 3'd0, lat, nw);
    chk("t2_wrap_addr", last_addr, 13'h01F);
    chk("t2_wrap_cursor", {cur_row, cur_col}, {5'd1, 5'd0});
    send(8'h0D, 3'd0, lat, nw);
    chk("t2_cr_writes", nw, 0);
    send(8'h08, 3'd0, lat, nw);
    chk("t2_bs0_writes", nw, 0);
    chk("t2_bs0_cursor", {cur_row, cur_col}, {5'd1, 5'd0});
    send(8'h78, 3'd0, lat, nw);
    send(8'h79, 3'd0, lat, nw);
    send(8'h08, 3'd0, lat, nw);
    chk("t2_bs_addr", last_addr, 13'h021);
    chk("t2_bs_data", last_data, 8'h20);
    chk("t2_bs_latency", lat, 2);
    check_page(0);
    check_page(2);

    // T4: clear page 7, ordered, then again under random grants
    seq_addr = 13'h1C00; seq_on = 1'b1;
    send(8'h0C, 3'd7, lat, nw);
    seq_on = 1'b0;
    chk("t4_cls_latency", lat, 1025);
    chk("t4_cls_writes", nw, 1024);
    chk("t4_last_addr", last_addr, 13'h1FFF);
    chk("t4_cursor", {cur_row, cur_col}, 0);
    check_page(7);
    for (int i = 0; i < 6; i++) send(rnd_print(), 3'd7, lat, nw);
    gnt_random = 1'b1;
    send(8'h0C, 3'd7, lat, nw);
    gnt_random = 1'b0;
    check_page(7);

    // T3: scroll of a page preloaded with row indices
    send(8'h0C, 3'd5, lat, nw);
    for (int i = 0; i < 31; i++) send(8'h0A, 3'd5, lat, nw);
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i), 3'd5, lat, nw);
    chk("t3_start_cursor", {cur_row, cur_col}, {5'd31, 5'd5});
    for (int rr = 0; rr < 32; rr++)
      for (int c = 0; c < 32; c++) begin
        dut_mem[5 * 1024 + rr * 32 + c] = 8'(rr);
        ref_mem[5 * 1024 + rr * 32 + c] = 8'(rr);
      end
    send(8'h0A, 3'd5, lat, nw);
    chk("t3_latency", lat, 2017);
    chk("t3_writes", nw, 1024);
    chk("t3_cursor", {cur_row, cur_col}, {5'd31, 5'd0});
    chk("t3_cell_0_0", dut_mem[5120], 1);
    chk("t3_cell_30_31", dut_mem[5120 + 30 * 32 + 31], 31);
    chk("t3_cell_31_0", dut_mem[5120 + 31 * 32], 8'h20);
    check_page(5);

    // T6: three bytes with in_valid held high
    q[0] = 8'h50; q[1] = 8'h51; q[2] = 8'h52;
    w0 = wr_count;
    @(posedge clk); #1;
    in_valid = 1'b1; page = 3'd5; in_data = q[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!in_ready && n < 1000);
      chk("t6_accept", in_ready, 1);
      op_page = 3'd5;
      @(posedge clk); #1;
      model_apply(q[i], 5, exp_w);
      if (i < 2) in_data = q[i + 1];
      else in_valid = 1'b0;
    end
    wait_ready(n);
    chk("t6_writes", wr_count - w0, 3);
    chk("t6_cursor", {cur_row, cur_col}, {5'd31, 5'd3});
    check_page(5);

    // randomized traffic with random grants
    gnt_random = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'h0A;
      else if (r < 14) b = 8'h0D;
      else if (r < 20) b = 8'h08;
      else if (r < 21) b = 8'h0C;
      else b = rnd_print();
      op_page = 3'($urandom);
      send(b, op_page, lat, nw);
      check_page(int'(op_page));
    end
    gnt_random = 1'b0;
    for (int p = 0; p < 8; p++) check_page(p);

    // T5: reset in the middle of a scroll
    send(8'h0C, 3'd3, lat, nw);
    for (int i = 0; i < 31; i++) send(8'h0A, 3'd3, lat, nw);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h0A; page = 3'd3;
    wait_ready(n);
    op_page = 3'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_bus_req", bus_req, 0);
    chk("t5_vram_we", vram_we, 0);
    chk("t5_cursor", {cur_row, cur_col}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    ref_row = 0; ref_col = 0;
    wait_ready(n);
    send(8'h5A, 3'd3, lat, nw);
    chk("t5_cell0", dut_mem[3 * 1024], 8'h5A);
    send(8'h0C, 3'd3, lat, nw);
    check_page(3);
    check_page(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
